// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
//   Byte-level command decoder placed directly behind the SPI mode-0 slave.
//   It parses a framed header (OPC, ADDR_H, ADDR_L[, LEN]), issues single-cycle
//   writes and reads on the internal register bus, and hands read data back to
//   the slave's transmit port. A high cs_n_i always restarts parsing at OPC.
//
//   Build option: define SPI_CMD_BURST_EN to add the LEN header byte, so a
//   frame carries N = LEN+1 data bytes with address auto-increment. Without
//   it the header is OPC, ADDR_H, ADDR_L and every frame moves one byte.
//
// Ports
//   clk          system clock (same domain as the SPI slave)
//   rst          synchronous, active-high reset
//   cs_n_i       SPI chip select; high marks a frame boundary
//   rx_data_i    received byte          rx_valid_i  one-cycle strobe for rx_data_i
//   tx_data_o    next byte to shift out tx_valid_o  tx_data_o holds fresh read data
//   bus_addr_o   bus address (ADDR_W)   bus_wdata_o write data
//   bus_we_o     one-cycle write strobe bus_re_o    one-cycle read strobe
//   bus_rdata_i  read data, sampled at the edge that ends the bus_re_o cycle
//   cmd_err_o    one-cycle pulse on an unknown opcode
module spi_cmd_decoder #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [7:0]        bus_wdata_o,
   output logic              bus_we_o,
   output logic              bus_re_o,
   input  logic [7:0]        bus_rdata_i,
   output logic              cmd_err_o
);

   localparam logic [2:0] S_OPC     = 3'd0;
   localparam logic [2:0] S_ADDR_H  = 3'd1;
   localparam logic [2:0] S_ADDR_L  = 3'd2;
`ifdef SPI_CMD_BURST_EN
   localparam logic [2:0] S_LEN     = 3'd3;
`endif
   localparam logic [2:0] S_WR_DATA = 3'd4;
   localparam logic [2:0] S_RD_TURN = 3'd5;
   localparam logic [2:0] S_RD_DATA = 3'd6;
   localparam logic [2:0] S_DISCARD = 3'd7;

   localparam logic [7:0]        OPC_WRITE = 8'h01;
   localparam logic [7:0]        OPC_READ  = 8'h02;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   // The header always carries 16 address bits; zero-extend or truncate to the bus width.
   function automatic logic [ADDR_W-1:0] fit_addr(input logic [15:0] hdr);
      return ADDR_W'(hdr);
   endfunction

   logic [2:0]        state_q,     state_d;
   logic              rd_op_q,     rd_op_d;
   logic [7:0]        addr_h_q,    addr_h_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [8:0]        cnt_q,       cnt_d;
   logic [7:0]        tx_data_q,   tx_data_d;
   logic              tx_valid_q,  tx_valid_d;
   logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
   logic [7:0]        bus_wdata_q, bus_wdata_d;
   logic              bus_we_q,    bus_we_d;
   logic              bus_re_q,    bus_re_d;
   logic              cmd_err_q,   cmd_err_d;

   logic [ADDR_W-1:0] hdr_addr_s;
   logic [8:0]        n_total_s;
   logic [8:0]        cnt_inc_s;
   logic              last_s;

`ifdef SPI_CMD_BURST_EN
   logic [7:0]        len_q,       len_d;
   assign n_total_s = {1'b0, len_q} + 9'd1;
`else
   assign n_total_s = 9'd1;
`endif

   assign hdr_addr_s = fit_addr({addr_h_q, rx_data_i});
   assign cnt_inc_s  = cnt_q + 9'd1;
   // cnt_q counts bytes already written or loaded; this byte completes the transfer.
   assign last_s     = (cnt_inc_s == n_total_s);

   // Next-state decode: frame parsing, bus strobes and read-return loading
   always_comb begin
      state_d     = state_q;
      rd_op_d     = rd_op_q;
      addr_h_d    = addr_h_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_we_d    = 1'b0;
      bus_re_d    = 1'b0;
      cmd_err_d   = 1'b0;
`ifdef SPI_CMD_BURST_EN
      len_d       = len_q;
`endif
      if (cs_n_i) begin
         // Boundary beats a same-cycle byte; an in-flight read return is not loaded.
         state_d    = S_OPC;
         tx_valid_d = 1'b0;
         cnt_d      = 9'd0;
      end else begin
         if (rx_valid_i) begin
            case (state_q)
               S_OPC: begin
                  cnt_d = 9'd0;
                  if (rx_data_i == OPC_WRITE) begin
                     rd_op_d = 1'b0;
                     state_d = S_ADDR_H;
                  end else if (rx_data_i == OPC_READ) begin
                     rd_op_d = 1'b1;
                     state_d = S_ADDR_H;
                  end else begin
                     cmd_err_d = 1'b1;
                     state_d   = S_DISCARD;
                  end
               end
               S_ADDR_H: begin
                  addr_h_d = rx_data_i;
                  state_d  = S_ADDR_L;
               end
`ifdef SPI_CMD_BURST_EN
               S_ADDR_L: begin
                  addr_d  = hdr_addr_s;
                  state_d = S_LEN;
               end
               S_LEN: begin
                  len_d = rx_data_i;
                  cnt_d = 9'd0;
                  if (rd_op_q) begin
                     // First read goes out as soon as the header is complete.
                     state_d    = S_RD_TURN;
                     bus_re_d   = 1'b1;
                     bus_addr_d = addr_q;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
`else
               S_ADDR_L: begin
                  addr_d = hdr_addr_s;
                  cnt_d  = 9'd0;
                  if (rd_op_q) begin
                     state_d    = S_RD_TURN;
                     bus_re_d   = 1'b1;
                     bus_addr_d = hdr_addr_s;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
`endif
               S_WR_DATA: begin
                  bus_we_d    = 1'b1;
                  bus_wdata_d = rx_data_i;
                  bus_addr_d  = addr_q;
                  addr_d      = addr_q + ADDR_ONE;
                  cnt_d       = cnt_inc_s;
                  if (last_s) begin
                     state_d = S_DISCARD;
                  end else begin
                     state_d = S_WR_DATA;
                  end
               end
               S_RD_TURN, S_RD_DATA: begin
                  // This strobe is the slave loading tx_data_o (or 0x00 on underrun).
                  tx_valid_d = 1'b0;
                  addr_d     = addr_q + ADDR_ONE;
                  cnt_d      = cnt_inc_s;
                  if (last_s) begin
                     state_d = S_DISCARD;
                  end else begin
                     state_d    = S_RD_DATA;
                     bus_re_d   = 1'b1;
                     bus_addr_d = addr_q + ADDR_ONE;
                  end
               end
               S_DISCARD: begin
                  state_d = S_DISCARD;
               end
               default: begin
                  state_d = S_DISCARD;
               end
            endcase
         end else begin
            state_d = state_q;
         end
         // Read data is captured in the cycle after the strobe, after any clear above.
         if (bus_re_q) begin
            tx_data_d  = bus_rdata_i;
            tx_valid_d = 1'b1;
         end else begin
            tx_data_d = tx_data_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_OPC;
         rd_op_q     <= 1'b0;
         addr_h_q    <= 8'h00;
         addr_q      <= {ADDR_W{1'b0}};
         cnt_q       <= 9'd0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
         bus_addr_q  <= {ADDR_W{1'b0}};
         bus_wdata_q <= 8'h00;
         bus_we_q    <= 1'b0;
         bus_re_q    <= 1'b0;
         cmd_err_q   <= 1'b0;
`ifdef SPI_CMD_BURST_EN
         len_q       <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         rd_op_q     <= rd_op_d;
         addr_h_q    <= addr_h_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_re_q    <= bus_re_d;
         cmd_err_q   <= cmd_err_d;
`ifdef SPI_CMD_BURST_EN
         len_q       <= len_d;
`endif
      end
   end

   assign tx_data_o   = tx_data_q;
   assign tx_valid_o  = tx_valid_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_we_o    = bus_we_q;
   assign bus_re_o    = bus_re_q;
   assign cmd_err_o   = cmd_err_q;

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Byte-level command decoder sitting directly downstream of the SPI mode-0 slave. Consumes received bytes (`rx_data`/`rx_valid`), parses a framed opcode/address/length header, issues single-cycle writes and reads on the internal register/memory bus, and returns read data to the slave's transmit port (`tx_data`/`tx_valid`). `cs_n` delimits frames, and every frame starts fresh at the opcode byte.

## Interface
- `ADDR_W`, 16: bus address width; the header always carries 16 address bits, zero-extended or truncated to `ADDR_W`.
- `clk`  in  1  system clock, same domain as the SPI slave.
- `rst`  in  1  synchronous, active-high reset.
- `cs_n`  in  1  SPI chip select (same signal the slave sees); high means frame boundary.
- `rx_data`  in  8  byte from the SPI slave.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid.
- `tx_data`  out  8  next byte for the slave to shift out.
- `tx_valid`  out  1  `tx_data` holds fresh read data. The slave samples both on the `rx_valid` cycle.
- `bus_addr`  out  `ADDR_W`  bus address.
- `bus_wdata`  out  8  write data.
- `bus_we`  out  1  one-cycle write strobe.
- `bus_re`  out  1  one-cycle read strobe.
- `bus_rdata`  in  8  read data, valid exactly 1 cycle after `bus_re` (fixed latency).
- `cmd_err`  out  1  one-cycle pulse on an unknown opcode.

## Operation
- Frame format: `OPC`, `ADDR_H`, `ADDR_L`, `LEN` (burst builds only), then data bytes. N = `LEN`+1 (1..256).
- Opcodes: 0x01 WRITE, 0x02 READ. Any other value pulses `cmd_err` and enters DISCARD.
- States: OPC → ADDR_H → ADDR_L → [LEN] → WR_DATA or RD_TURN → RD_DATA → DISCARD. Each transition occurs on `rx_valid`.
- WRITE, WR_DATA state: each `rx_valid` gives `bus_we`=1, `bus_wdata`=`rx_data`, `bus_addr`=current address, all in the cycle after `rx_valid`. The address then increments, wrapping modulo 2^`ADDR_W`. After N bytes the block enters DISCARD.
- READ: entering RD_TURN issues `bus_re` at the header address. The cycle after, the block latches `bus_rdata` into `tx_data` and sets `tx_valid`=1.
- The master sends one dummy turnaround byte; its `rx_valid` is the cycle in which the slave loads `tx_data`. Read byte k is therefore shifted out during the k-th byte after the turnaround.
- In RD_TURN/RD_DATA, each `rx_valid` does the following:
  - clears `tx_valid` in the same cycle;
  - increments the address;
  - if fewer than N bytes have been loaded, issues the next `bus_re` in the following cycle;
  - after the N-th load, enters DISCARD.
- DISCARD: ignores all bytes; no bus activity.
- `cs_n`=1 in any cycle gives state=OPC, `tx_valid`=0, and byte counter=0. A pending read return is dropped and not loaded. `cs_n` takes priority over a simultaneous `rx_valid`.
- Underrun: if `rx_valid` arrives while `tx_valid`=0 in a read phase, the slave shifts 0x00. The decoder still advances exactly as for a normal load.
- Received byte values in RD_TURN, RD_DATA and DISCARD are ignored.

## Timing
- Reset values: `tx_data`=0x00, `tx_valid`=0, `bus_addr`=0, `bus_wdata`=0x00, `bus_we`=0, `bus_re`=0, `cmd_err`=0, state=OPC.
- `bus_we`, `bus_re` and `cmd_err` are registered, one cycle after the triggering `rx_valid` (or after header completion for the first `bus_re`).
- Read-to-`tx_valid`: 2 cycles after the `rx_valid` that triggered it (`bus_re` at +1, load at +2). This is well within one SPI byte (≥16 `clk`).
- At most one bus strobe per cycle; `bus_we` and `bus_re` are never both high.

## Configuration
- `SPI_CMD_BURST_EN` defined: the `LEN` header byte is present, giving N = `LEN`+1 with address auto-increment.
- Undefined: no `LEN` byte and N fixed at 1, so the header is OPC, ADDR_H, ADDR_L. The WR_DATA/RD_DATA counters reduce to a single transfer.

## Test plan
- Burst build, write: frame 01 12 34 01 AA BB → `bus_we` twice: (0x1234, 0xAA), then (0x1235, 0xBB). A trailing byte 0xCC produces no strobe.
- Burst build, read: frame 02 00 10 02 + 4 dummy bytes, bus memory [0x10]=0x5A, [0x11]=0x5B, [0x12]=0x5C → MISO bytes after the turnaround are 5A 5B 5C. Exactly 3 `bus_re` pulses.
- Bad opcode 0x7F → `cmd_err` pulses once; subsequent bytes give no bus strobes until `cs_n` rises. The next frame 01 00 00 00 11 writes 0x11 to address 0.
- Abort: `cs_n` rises after ADDR_H of a WRITE → no `bus_we`. A new frame parses from OPC correctly; `tx_valid`=0 after the abort.
- Wrap: burst write at 0xFFFF with `LEN`=1 → writes at 0xFFFF then 0x0000.
- Non-burst build: 02 00 05 + 1 dummy → single `bus_re` at 0x0005; its data is returned in the byte after the dummy.
